uart_dec_parser: RTL and testbench

Sits directly downstream of uart_rx and consumes its byte stream (dout/dval_out/idle_out).
Accumulates ASCII decimal digits ('0'..'9') into an unsigned binary value and emits the value as a one-cycle result strobe.
A number is terminated by CR, LF, or the receive line going idle.
Malformed input or overflow yields an error strobe instead of a value.
Used for setting numeric registers over the 57600-baud, 8E1 control link.

---
 rtl/uart_dec_parser.sv | 113 +++++++++++
 tb/tb_uart_dec_parser.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_dec_parser.sv
// uart_dec_parser: accumulates ASCII decimal digits from uart_rx into an unsigned WIDTH-bit value.
// Result/error strobe one cycle after CR/LF or idle rise; no backpressure, every dval_in byte is consumed.
module uart_dec_parser #(
   parameter int WIDTH        = 32,
   parameter int TERM_ON_IDLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       din,
   input  logic             dval_in,
   input  logic             idle_in,
   output logic [WIDTH-1:0] value_out,
   output logic             vld_out,
   output logic             err_out,
   output logic             busy_out
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DISCARD
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             vld_q, vld_d;
   logic             err_q, err_d;
   logic             idle_q;
   logic             is_digit, is_term, idle_edge, term;
   logic [WIDTH+3:0] mul10;

   assign is_digit  = (din >= 8'h30) && (din <= 8'h39);
   assign is_term   = (din == 8'h0D) || (din == 8'h0A);
   assign idle_edge = (TERM_ON_IDLE != 0) && idle_in && !idle_q;
   // acc*10 + digit in WIDTH+4 bits; any set bit above WIDTH means overflow
   assign mul10     = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
                    + {{WIDTH{1'b0}}, din[3:0]};

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      value_d = value_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      term    = 1'b0;

      if (dval_in) begin
         if (is_digit) begin
            case (state_q)
               ST_IDLE: begin
                  acc_d   = WIDTH'(din[3:0]);
                  state_d = ST_ACCUM;
               end
               ST_ACCUM: begin
                  if (mul10[WIDTH+3:WIDTH] != 4'd0) begin
                     acc_d   = '0;
                     state_d = ST_DISCARD;
                  end else begin
                     acc_d = mul10[WIDTH-1:0];
                  end
               end
               default: ;
            endcase
         end else if (is_term) begin
            term = 1'b1;
         end else begin
            acc_d   = '0;
            state_d = ST_DISCARD;
         end
      end

      // Idle edge terminates after the same-cycle byte has been applied
      if (idle_edge) term = 1'b1;

      if (term) begin
         case (state_d)
            ST_ACCUM: begin
               value_d = acc_d;
               vld_d   = 1'b1;
            end
            ST_DISCARD: err_d = 1'b1;
            default: ;
         endcase
         state_d = ST_IDLE;
         acc_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         value_q <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         idle_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         value_q <= value_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         idle_q  <= idle_in;
      end
   end

   assign value_out = value_q;
   assign vld_out   = vld_q;
   assign err_out   = err_q;
   assign busy_out  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_dec_parser.sv
// Bench for uart_dec_parser: directed test-plan sequences plus random bytes against a number-level model.
module tb_uart_dec_parser;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        dval_in;
   logic        idle_in;
   logic [31:0] value_out;
   logic        vld_out;
   logic        err_out;
   logic        busy_out;

   int total = 0;
   int bad   = 0;
   int nvld  = 0;
   int nerr  = 0;

   // Model: the current number as text-level facts (started, rejected, numeric value)
   bit              m_in;
   bit              m_bad;
   longint unsigned m_val;
   logic [31:0]     m_value;
   bit              m_prev_idle;
   localparam longint unsigned MAXV = 64'hFFFF_FFFF;

   uart_dec_parser #(.WIDTH(32), .TERM_ON_IDLE(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .dval_in  (dval_in),
      .idle_in  (idle_in),
      .value_out(value_out),
      .vld_out  (vld_out),
      .err_out  (err_out),
      .busy_out (busy_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_in        = 0;
      m_bad       = 0;
      m_val       = 0;
      m_value     = 32'd0;
      m_prev_idle = 1;
   endtask

   task automatic step(input logic dv, input logic [7:0] b, input logic idl);
      bit ev, ee, finish_num, edge_seen;
      ev = 0;
      ee = 0;
      finish_num = 0;
      edge_seen = idl && !m_prev_idle;
      m_prev_idle = idl;
      if (dv) begin
         if (b >= 8'h30 && b <= 8'h39) begin
            if (!m_in) begin
               m_in  = 1;
               m_bad = 0;
               m_val = longint'(b - 8'h30);
            end else if (!m_bad) begin
               m_val = m_val * 10 + longint'(b - 8'h30);
               if (m_val > MAXV) m_bad = 1;
            end
         end else if (b == 8'h0D || b == 8'h0A) begin
            finish_num = 1;
         end else begin
            m_in  = 1;
            m_bad = 1;
         end
      end
      if (edge_seen) finish_num = 1;
      if (finish_num && m_in) begin
         if (m_bad) ee = 1;
         else begin
            ev = 1;
            m_value = m_val[31:0];
         end
         m_in  = 0;
         m_bad = 0;
         m_val = 0;
      end

      dval_in = dv;
      din     = b;
      idle_in = idl;
      @(posedge clk);
      #1;
      dval_in = 1'b0;
      nvld += int'(vld_out);
      nerr += int'(err_out);
      chk("vld", {63'd0, vld_out}, {63'd0, ev});
      chk("err", {63'd0, err_out}, {63'd0, ee});
      chk("value", {32'd0, value_out}, {32'd0, m_value});
      chk("busy", {63'd0, busy_out}, {63'd0, m_in});
      chk("vld_err_excl", {63'd0, vld_out & err_out}, 64'd0);
   endtask

   task automatic send_str(input string s, input logic idl);
      for (int i = 0; i < s.len(); i++) step(1'b1, s[i], idl);
   endtask

   initial begin
      logic [7:0] bad_bytes [7];
      logic [7:0] b;
      logic       idl;
      logic       dv;
      int         r;
      bad_bytes = '{8'h20, 8'h68, 8'h2D, 8'h00, 8'hFF, 8'h2F, 8'h3A};

      rst     = 1'b1;
      din     = 8'h00;
      dval_in = 1'b0;
      idle_in = 1'b1;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_value", {32'd0, value_out}, 64'd0);
      chk("rst_vld", {63'd0, vld_out}, 64'd0);
      chk("rst_err", {63'd0, err_out}, 64'd0);
      chk("rst_busy", {63'd0, busy_out}, 64'd0);
      rst = 1'b0;

      // 1: "192" then idle rise
      nvld = 0; nerr = 0;
      send_str("192", 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("t1_value", {32'd0, value_out}, 64'd192);
      chk("t1_nvld", nvld, 1);
      chk("t1_nerr", nerr, 0);

      // 2: "hi" then idle rise -> error, value held
      nvld = 0; nerr = 0;
      send_str("hi", 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("t2_value", {32'd0, value_out}, 64'd192);
      chk("t2_nvld", nvld, 0);
      chk("t2_nerr", nerr, 1);

      // 3: max value then overflow by one
      nvld = 0; nerr = 0;
      send_str("4294967295", 1'b0);
      step(1'b1, 8'h0D, 1'b0);
      chk("t3_max", {32'd0, value_out}, 64'hFFFF_FFFF);
      send_str("4294967296", 1'b0);
      step(1'b1, 8'h0A, 1'b0);
      chk("t3_ovf_value", {32'd0, value_out}, 64'hFFFF_FFFF);
      chk("t3_nvld", nvld, 1);
      chk("t3_nerr", nerr, 1);

      // 4: empty number, then "12\r" + idle rise, then simultaneous cases
      nvld = 0; nerr = 0;
      step(1'b1, 8'h0D, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("t4_empty", nvld + nerr, 0);
      send_str("12\r", 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("t4_value", {32'd0, value_out}, 64'd12);
      chk("t4_nvld", nvld, 1);
      send_str("5", 1'b0);
      step(1'b1, 8'h0D, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("t4_term_edge", nvld, 2);
      send_str("3", 1'b0);
      step(1'b1, 8'h34, 1'b1);
      chk("t4_digit_edge", {32'd0, value_out}, 64'd34);
      send_str("007", 1'b0);
      step(1'b1, 8'h20, 1'b1);
      chk("t4_bad_edge_nerr", nerr, 1);
      chk("t4_bad_edge_value", {32'd0, value_out}, 64'd34);

      // 5: reset mid-number
      nvld = 0; nerr = 0;
      send_str("12", 1'b0);
      rst = 1'b1;
      #2;
      chk("t5_rst_value", {32'd0, value_out}, 64'd0);
      chk("t5_rst_busy", {63'd0, busy_out}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      step(1'b1, 8'h37, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("t5_value", {32'd0, value_out}, 64'd7);
      chk("t5_nvld", nvld, 1);
      chk("t5_nerr", nerr, 0);

      // 6: random bytes and idle toggling
      idl = 1'b0;
      for (int n = 0; n < 200; n++) begin
         dv = ($urandom_range(0, 3) != 0);
         r  = $urandom_range(0, 99);
         if (r < 65)      b = 8'h30 + 8'($urandom_range(0, 9));
         else if (r < 80) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
         else             b = bad_bytes[$urandom_range(0, 6)];
         if ($urandom_range(0, 7) == 0) idl = ~idl;
         step(dv, b, idl);
      end
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
